// File: rtl/noc_wrap_link_ctrl.sv
// Inter-router link stage: STAGES-deep flit and credit pipelines plus runtime
// drain / disable / wake control so a wrap-around channel can be shut off cleanly.
module noc_wrap_link_ctrl #(
  parameter int Fw      = 32,
  parameter int V       = 2,
  parameter int B       = 4,
  parameter int STAGES  = 2,
  parameter bit INIT_EN = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          link_en,
  input  logic [Fw-1:0] flit_in,
  input  logic          flit_in_wr,
  input  logic [V-1:0]  flit_in_vc,
  output logic [Fw-1:0] flit_out,
  output logic          flit_out_wr,
  output logic [V-1:0]  flit_out_vc,
  input  logic [V-1:0]  credit_in,
  output logic [V-1:0]  credit_out,
  output logic          link_up,
  output logic [1:0]    link_state,
  output logic          err_flit_down,
  output logic          err_credit
);

  localparam int CW = $clog2(B + 1);
  localparam int WW = 4;
  localparam logic [CW-1:0] CNT_MAX   = CW'(B);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [WW-1:0] WAKE_LOAD = WW'(STAGES);
  localparam logic [WW-1:0] WAKE_ONE  = WW'(1);
  localparam logic [WW-1:0] WAKE_ZERO = {WW{1'b0}};

  typedef enum logic [1:0] {
    ST_DISABLED = 2'b00,
    ST_WAKE     = 2'b01,
    ST_ACTIVE   = 2'b10,
    ST_DRAIN    = 2'b11
  } state_t;

  localparam state_t RESET_STATE = INIT_EN ? ST_ACTIVE : ST_DISABLED;

  logic [Fw-1:0]     flit_pipe_r [STAGES];
  logic [V-1:0]      vc_pipe_r   [STAGES];
  logic [V-1:0]      cred_pipe_r [STAGES];
  logic [STAGES-1:0] valid_pipe_r;
  logic [CW-1:0]     cnt_r       [V];
  logic [CW-1:0]     cnt_next_s  [V];
  state_t            state_r, state_next_s;
  logic [WW-1:0]     wake_cnt_r, wake_cnt_next_s;
  logic              link_up_r, err_flit_down_r, err_credit_r;
  logic              accept_s, flit_down_s, cred_err_s, idle_s;

  // Flit acceptance: only ACTIVE and DRAIN let flits into the pipeline.
  always_comb begin
    accept_s    = flit_in_wr & ((state_r == ST_ACTIVE) | (state_r == ST_DRAIN));
    flit_down_s = flit_in_wr & ~accept_s;
  end

  // Per-VC outstanding credit counters with saturation and error detection.
  always_comb begin
    cred_err_s = 1'b0;
    for (int v = 0; v < V; v++) begin
      cnt_next_s[v] = cnt_r[v];
      if (accept_s && flit_in_vc[v] && !credit_in[v]) begin
        if (cnt_r[v] == CNT_MAX) begin
          cred_err_s = 1'b1;
        end else begin
          cnt_next_s[v] = cnt_r[v] + CNT_ONE;
        end
      end else if (credit_in[v] && !(accept_s && flit_in_vc[v])) begin
        if (cnt_r[v] == CNT_ZERO) begin
          cred_err_s = 1'b1;
        end else begin
          cnt_next_s[v] = cnt_r[v] - CNT_ONE;
        end
      end else begin
        cnt_next_s[v] = cnt_r[v];
      end
    end
  end

  // Idle: nothing owed downstream and nothing still travelling in either pipe.
  always_comb begin
    idle_s = ~|valid_pipe_r;
    for (int v = 0; v < V; v++) begin
      idle_s = idle_s & (cnt_r[v] == CNT_ZERO);
    end
    for (int s = 0; s < STAGES; s++) begin
      idle_s = idle_s & ~|cred_pipe_r[s];
    end
  end

  // Link state machine; a re-enable request always wins over completing a drain.
  always_comb begin
    state_next_s    = state_r;
    wake_cnt_next_s = wake_cnt_r;
    case (state_r)
      ST_ACTIVE: begin
        if (!link_en) state_next_s = ST_DRAIN;
        else          state_next_s = ST_ACTIVE;
      end
      ST_DRAIN: begin
        if (link_en)     state_next_s = ST_ACTIVE;
        else if (idle_s) state_next_s = ST_DISABLED;
        else             state_next_s = ST_DRAIN;
      end
      ST_DISABLED: begin
        if (link_en) begin
          state_next_s    = ST_WAKE;
          wake_cnt_next_s = WAKE_LOAD;
        end else begin
          state_next_s    = ST_DISABLED;
        end
      end
      ST_WAKE: begin
        if (!link_en) begin
          state_next_s    = ST_DISABLED;
          wake_cnt_next_s = WAKE_ZERO;
        end else if (wake_cnt_r <= WAKE_ONE) begin
          state_next_s    = ST_ACTIVE;
          wake_cnt_next_s = WAKE_ZERO;
        end else begin
          state_next_s    = ST_WAKE;
          wake_cnt_next_s = wake_cnt_r - WAKE_ONE;
        end
      end
      default: begin
        state_next_s    = RESET_STATE;
        wake_cnt_next_s = WAKE_ZERO;
      end
    endcase
  end

  // Pipelines, counters, state and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < STAGES; s++) begin
        flit_pipe_r[s] <= '0;
        vc_pipe_r[s]   <= '0;
        cred_pipe_r[s] <= '0;
      end
      valid_pipe_r <= '0;
      for (int v = 0; v < V; v++) begin
        cnt_r[v] <= CNT_ZERO;
      end
      state_r         <= RESET_STATE;
      wake_cnt_r      <= WAKE_ZERO;
      link_up_r       <= INIT_EN;
      err_flit_down_r <= 1'b0;
      err_credit_r    <= 1'b0;
    end else begin
      flit_pipe_r[0]  <= accept_s ? flit_in : '0;
      vc_pipe_r[0]    <= accept_s ? flit_in_vc : '0;
      valid_pipe_r[0] <= accept_s;
      cred_pipe_r[0]  <= credit_in;
      for (int s = 1; s < STAGES; s++) begin
        flit_pipe_r[s]  <= flit_pipe_r[s-1];
        vc_pipe_r[s]    <= vc_pipe_r[s-1];
        valid_pipe_r[s] <= valid_pipe_r[s-1];
        cred_pipe_r[s]  <= cred_pipe_r[s-1];
      end
      for (int v = 0; v < V; v++) begin
        cnt_r[v] <= cnt_next_s[v];
      end
      state_r         <= state_next_s;
      wake_cnt_r      <= wake_cnt_next_s;
      link_up_r       <= (state_next_s == ST_ACTIVE);
      err_flit_down_r <= err_flit_down_r | flit_down_s;
      err_credit_r    <= err_credit_r | cred_err_s;
    end
  end

  assign flit_out      = flit_pipe_r[STAGES-1];
  assign flit_out_wr   = valid_pipe_r[STAGES-1];
  assign flit_out_vc   = vc_pipe_r[STAGES-1];
  assign credit_out    = cred_pipe_r[STAGES-1];
  assign link_up       = link_up_r;
  assign link_state    = state_r;
  assign err_flit_down = err_flit_down_r;
  assign err_credit    = err_credit_r;

endmodule
